test_reg_master: RTL
====================

# test_reg_master

Register-interface initiator that drives the same reg_req/reg_rsp bus the test CSR blocks respond on. It executes a queued sequence of WRITE, READ, POLL and WAIT commands against a responder and returns read data on a valid/ready result port. It sits between a testbench or sequencer and a CSR block, and automates descriptor programming, execute pulses and done-polling with no per-access software involvement.

## Interface
Parameters:
- reg_req_t, logic: request struct with fields addr, write, wdata, wstrb, valid.
- reg_rsp_t, logic: response struct with fields rdata, error, ready.
- CMD_DEPTH, 4: command FIFO depth. Must be a power of two, ≥2.
- POLL_MAX, 16: maximum reads per POLL command before timeout.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted; equals !fifo_full.
- cmd_op_i  in  2  0=WRITE, 1=READ, 2=POLL, 3=WAIT.
- cmd_addr_i  in  8  register byte address.
- cmd_data_i  in  32  write data (WRITE), match mask (POLL), cycle count (WAIT); ignored for READ.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_data_o  out  32  captured rdata.
- res_err_o  out  1  bus error or poll timeout for this result.
- busy_o  out  1  FIFO non-empty or FSM not IDLE.
- error_o  out  1  sticky; set on any response with error=1 or any poll timeout.
- reg_req_o  out  reg_req_t  bus request.
- reg_rsp_i  in  reg_rsp_t  bus response.

## Operation
- Command FIFO: push on cmd_valid_i && cmd_ready_o. The head entry is popped only when its command completes. No bypass path; push and pop may happen in the same cycle.
- FSM states: IDLE, ISSUE, GAP, WAIT, RESULT.
- IDLE:
  - FIFO non-empty, op WRITE/READ/POLL → ISSUE.
  - FIFO non-empty, op WAIT → WAIT; counter loaded with cmd_data.
- ISSUE drives the bus:
  - valid=1, addr={24'b0,cmd_addr}, write=(op==WRITE).
  - wdata=cmd_data for WRITE, else 0; wstrb=4'hF for WRITE, else 4'h0.
  - All fields hold until reg_rsp_i.ready=1. A transfer completes in any cycle where valid && ready.
- On completion from ISSUE:
  - WRITE → pop, IDLE. No result is produced. Response error sets error_o.
  - READ → capture rdata and error into res_data/res_err → RESULT.
  - POLL, (rdata & mask)!=0 or error → capture → RESULT.
  - POLL, no match: increment poll_cnt. If poll_cnt reaches POLL_MAX → capture last rdata, res_err=1 → RESULT. Otherwise → GAP.
- GAP: valid=0 for exactly one cycle → ISSUE.
- WAIT: counter decrements each cycle; at 0 → pop, IDLE. A count of 0 is treated as 1 cycle.
- RESULT: res_valid_o=1 until res_ready_i. On handshake → pop, clear poll_cnt, IDLE.
- res_data_o and res_err_o stay stable while res_valid_o=1.
- error_o is cleared only by reset.

## Timing
- Reset values:
  - FSM=IDLE, FIFO empty, cmd_ready_o=1, res_valid_o=0, res_data_o=0, res_err_o=0, busy_o=0, error_o=0.
  - reg_req_o all fields 0.
- reg_req_o.valid is decoded from the registered state; it deasserts asynchronously on reset, including mid-transfer.
- Latency, empty FIFO: command accepted at edge E → IDLE sees the head in cycle E+1 → reg valid in cycle E+2.
- Zero-wait responder (ready=1):
  - READ: res_valid_o in the cycle after the transfer cycle.
  - WRITE: next command's ISSUE 2 cycles after the transfer cycle.
- POLL: consecutive read transfers are ≥2 cycles apart because of GAP.
- Full FIFO: cmd_ready_o=0. A pop in the same cycle frees a slot from the next cycle only.
- Simultaneous push and pop at CMD_DEPTH-1 occupancy: the count is unchanged.

## Configuration
- TEST_REG_MASTER_WAIT_EN:
  - Defined: op 3 is WAIT as described.
  - Undefined: the WAIT state is not built; op 3 is popped in IDLE in one cycle with no bus activity and no result.

## Test plan
- WRITE 0x00←5, WRITE 0x04←7, READ 0x08 against the CSR → one result with res_data=0xC, res_err=0, error_o=0; no results for the writes.
- POLL 0x50 mask 1; test_done rises after the 3rd read → exactly 3 read transfers separated by 1 idle cycle; result data=1, err=0.
- POLL with done never set, POLL_MAX=16 → 16 reads, then result err=1 and error_o=1.
- Responder holds ready=0 for 5 cycles during a WRITE → req fields stable for 6 cycles; exactly one transfer.
- Push 5 commands with CMD_DEPTH=4 and res_ready_i=0 → cmd_ready_o=0 after 4 pushes; the 5th is accepted only after the first result handshake.
- Reset asserted mid-ISSUE → valid=0 immediately; FIFO empty; error_o=0; busy_o=0.
- With the macro defined, WAIT 10 → exactly 10 idle bus cycles before the next command's valid.

Source files
------------

// File: rtl/test_reg_master.sv
// test_reg_master: register-bus initiator that runs a queued sequence of WRITE, READ, POLL
// and WAIT commands against a CSR responder and returns read data on a valid/ready port.
// Optional build macro: TEST_REG_MASTER_WAIT_EN enables the WAIT state. Without it, op 3 is
// dropped in IDLE in one cycle with no bus activity and no result.
module test_reg_master #(
   parameter type reg_req_t = struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   },
   parameter type reg_rsp_t = struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   },
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned POLL_MAX  = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [7:0]  cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [31:0] res_data_o,
   output logic        res_err_o,
   output logic        busy_o,
   output logic        error_o,
   output reg_req_t    reg_req_o,
   input  reg_rsp_t    reg_rsp_i
);

   localparam int unsigned PtrW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(CMD_DEPTH + 1);
   localparam int unsigned PollW = $clog2(POLL_MAX + 1);

   localparam logic [1:0] OpWrite = 2'd0;
   localparam logic [1:0] OpRead  = 2'd1;
   localparam logic [1:0] OpWait  = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StGap,
`ifdef TEST_REG_MASTER_WAIT_EN
      StWait,
`endif
      StResult
   } state_e;

   state_e state_q, state_d;

   // Command FIFO storage and pointers
   logic [1:0]  fifo_op_q   [CMD_DEPTH];
   logic [7:0]  fifo_addr_q [CMD_DEPTH];
   logic [31:0] fifo_data_q [CMD_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;

   logic push, pop;
   logic fifo_empty;
   logic [1:0]  head_op;
   logic [7:0]  head_addr;
   logic [31:0] head_data;

   logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_err_q, res_err_d;
   logic        error_q, error_d;
`ifdef TEST_REG_MASTER_WAIT_EN
   logic [31:0] wait_cnt_q, wait_cnt_d;
`endif

   assign fifo_empty  = (count_q == '0);
   assign cmd_ready_o = (count_q != CntW'(CMD_DEPTH));
   assign push        = cmd_valid_i && cmd_ready_o;
   assign head_op     = fifo_op_q[rd_ptr_q];
   assign head_addr   = fifo_addr_q[rd_ptr_q];
   assign head_data   = fifo_data_q[rd_ptr_q];

   // FIFO payload write; storage needs no reset since count_q gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_op_q[wr_ptr_q]   <= cmd_op_i;
         fifo_addr_q[wr_ptr_q] <= cmd_addr_i;
         fifo_data_q[wr_ptr_q] <= cmd_data_i;
      end
   end

   // Occupancy; a pop frees a slot for pushes starting the following cycle
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, occupancy and FSM/result state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= StIdle;
         poll_cnt_q <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
         error_q    <= 1'b0;
`ifdef TEST_REG_MASTER_WAIT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q    <= count_d;
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
         error_q    <= error_d;
`ifdef TEST_REG_MASTER_WAIT_EN
         wait_cnt_q <= wait_cnt_d;
`endif
      end
   end

   // Next-state, pop and result capture
   always_comb begin
      state_d    = state_q;
      pop        = 1'b0;
      poll_cnt_d = poll_cnt_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;
      error_d    = error_q;
`ifdef TEST_REG_MASTER_WAIT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               if (head_op == OpWait) begin
`ifdef TEST_REG_MASTER_WAIT_EN
                  state_d    = StWait;
                  // A zero count still spends one cycle in WAIT
                  wait_cnt_d = (head_data == '0) ? 32'd1 : head_data;
`else
                  pop = 1'b1;
`endif
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            if (reg_rsp_i.ready) begin
               if (reg_rsp_i.error) error_d = 1'b1;
               if (head_op == OpWrite) begin
                  pop     = 1'b1;
                  state_d = StIdle;
               end else if (head_op == OpRead) begin
                  res_data_d = reg_rsp_i.rdata;
                  res_err_d  = reg_rsp_i.error;
                  state_d    = StResult;
               end else if (((reg_rsp_i.rdata & head_data) != '0) || reg_rsp_i.error) begin
                  res_data_d = reg_rsp_i.rdata;
                  res_err_d  = reg_rsp_i.error;
                  state_d    = StResult;
               end else if (poll_cnt_q == PollW'(POLL_MAX - 1)) begin
                  // Poll timeout: report the last value read with the error flag
                  poll_cnt_d = poll_cnt_q + PollW'(1);
                  res_data_d = reg_rsp_i.rdata;
                  res_err_d  = 1'b1;
                  error_d    = 1'b1;
                  state_d    = StResult;
               end else begin
                  poll_cnt_d = poll_cnt_q + PollW'(1);
                  state_d    = StGap;
               end
            end
         end
         StGap: begin
            state_d = StIssue;
         end
`ifdef TEST_REG_MASTER_WAIT_EN
         StWait: begin
            if (wait_cnt_q <= 32'd1) begin
               pop     = 1'b1;
               state_d = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q - 32'd1;
            end
         end
`endif
         StResult: begin
            if (res_ready_i) begin
               pop        = 1'b1;
               poll_cnt_d = '0;
               state_d    = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Bus request decoded from registered state so it drops immediately on reset
   always_comb begin
      reg_req_o = '0;
      if (state_q == StIssue) begin
         reg_req_o.valid = 1'b1;
         reg_req_o.addr  = {24'b0, head_addr};
         reg_req_o.write = (head_op == OpWrite);
         reg_req_o.wdata = (head_op == OpWrite) ? head_data : 32'd0;
         reg_req_o.wstrb = (head_op == OpWrite) ? 4'hF : 4'h0;
      end
   end

   assign res_valid_o = (state_q == StResult);
   assign res_data_o  = res_data_q;
   assign res_err_o   = res_err_q;
   assign busy_o      = !fifo_empty || (state_q != StIdle);
   assign error_o     = error_q;

endmodule
